// File: rtl/datapath_mc.sv
// datapath_mc: parametrised single-bus processor datapath with a multi-cycle
// signed multiply/divide unit beside the single-cycle ALU.
module datapath_mc #(
  parameter int WIDTH  = 32,
  parameter int NREG   = 16,
  parameter int ADDR_W = 9,
  localparam int SEL_W = $clog2(NREG + 8)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [SEL_W-1:0]  src_sel,
  input  logic              src_en,
  input  logic              ba_out,
  input  logic [NREG-1:0]   reg_in,
  input  logic              pc_in,
  input  logic              y_in,
  input  logic              hi_in,
  input  logic              lo_in,
  input  logic              c_in,
  input  logic              mar_in,
  input  logic              out_in,
  input  logic              inc_pc,
  input  logic              mdr_in,
  input  logic              mdr_read,
  input  logic [WIDTH-1:0]  mem_data_in,
  input  logic [WIDTH-1:0]  in_port,
  input  logic [3:0]        alu_op,
  input  logic              z_in,
  output logic [WIDTH-1:0]  bus,
  output logic [WIDTH-1:0]  mdr_out,
  output logic [ADDR_W-1:0] mar_addr,
  output logic [WIDTH-1:0]  out_port,
  output logic              alu_busy,
  output logic              alu_done
);

  localparam int REG_IW = $clog2(NREG);
  localparam int SH_W   = $clog2(WIDTH);
  localparam int CNT_W  = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] regs [NREG];
  logic [WIDTH-1:0] pc, y, hi, lo, zhi, zlo, c_reg;

  logic [WIDTH-1:0] alu_result;
  logic [SH_W-1:0]  sh;

  // Multiply/divide working state
  logic             is_div, neg_q, neg_r;
  logic [CNT_W-1:0] cnt;
  logic [2*WIDTH+1:0] booth_p;
  logic [WIDTH:0]   mcand;
  logic [WIDTH-1:0] div_q, div_rem, div_d;

  logic             start;
  logic [WIDTH:0]   booth_acc, booth_sum;
  logic [2*WIDTH+1:0] booth_next;
  logic [WIDTH:0]   div_shift, div_trial;
  logic [WIDTH-1:0] div_q_next, div_rem_next, quot_final, rem_final;
  logic [WIDTH-1:0] y_mag, bus_mag;

  // Bus source mux; R0 reads as zero when ba_out is set
  always_comb begin
    bus = '0;
    if (src_en) begin
      if (src_sel < SEL_W'(NREG)) begin
        if (!(ba_out && src_sel == '0)) bus = regs[src_sel[REG_IW-1:0]];
      end else begin
        case (src_sel)
          SEL_W'(NREG):     bus = hi;
          SEL_W'(NREG + 1): bus = lo;
          SEL_W'(NREG + 2): bus = zhi;
          SEL_W'(NREG + 3): bus = zlo;
          SEL_W'(NREG + 4): bus = pc;
          SEL_W'(NREG + 5): bus = mdr_out;
          SEL_W'(NREG + 6): bus = c_reg;
          SEL_W'(NREG + 7): bus = in_port;
          default:          bus = '0;
        endcase
      end
    end
  end

  // Single-cycle ALU: A is Y, B is the bus; rotates go through a doubled word
  always_comb begin
    sh = bus[SH_W-1:0];
    alu_result = '0;
    case (alu_op)
      4'd0:    alu_result = y + bus;
      4'd1:    alu_result = y - bus;
      4'd2:    alu_result = y & bus;
      4'd3:    alu_result = y | bus;
      4'd4:    alu_result = y >> sh;
      4'd5:    alu_result = $unsigned($signed(y) >>> sh);
      4'd6:    alu_result = y << sh;
      4'd7:    alu_result = WIDTH'({y, y} >> sh);
      4'd8:    alu_result = WIDTH'({y, y} >> (WIDTH - int'(sh)));
      4'd9:    alu_result = -bus;
      4'd10:   alu_result = ~bus;
      default: alu_result = '0;
    endcase
  end

  // Booth and restoring-division step logic plus final sign correction
  always_comb begin
    booth_acc = booth_p[2*WIDTH+1:WIDTH+1];
    case (booth_p[1:0])
      2'b01:   booth_sum = booth_acc + mcand;
      2'b10:   booth_sum = booth_acc - mcand;
      default: booth_sum = booth_acc;
    endcase
    booth_next   = {booth_sum[WIDTH], booth_sum, booth_p[WIDTH:1]};
    div_shift    = {div_rem, div_q[WIDTH-1]};
    div_trial    = div_shift - {1'b0, div_d};
    div_q_next   = {div_q[WIDTH-2:0], ~div_trial[WIDTH]};
    div_rem_next = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
    quot_final   = neg_q ? -div_q_next : div_q_next;
    rem_final    = neg_r ? -div_rem_next : div_rem_next;
    y_mag        = y[WIDTH-1] ? -y : y;
    bus_mag      = bus[WIDTH-1] ? -bus : bus;
  end

  // Mul/div FSM state register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_next;
  end

  // Mul/div next state and handshake outputs; divide by zero skips RUN
  always_comb begin
    state_next = state;
    alu_busy   = 1'b0;
    alu_done   = 1'b0;
    start      = (state == IDLE) && z_in && (alu_op == 4'd11 || alu_op == 4'd12);
    case (state)
      IDLE: if (start) state_next = (alu_op == 4'd12 && bus == '0) ? DONE : RUN;
      RUN: begin
        alu_busy = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) state_next = DONE;
      end
      DONE: begin
        alu_busy   = 1'b1;
        alu_done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Z register and mul/div iteration state; z_in only acts while idle
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      zhi     <= '0;
      zlo     <= '0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      cnt     <= '0;
      booth_p <= '0;
      mcand   <= '0;
      div_q   <= '0;
      div_rem <= '0;
      div_d   <= '0;
    end else begin
      case (state)
        IDLE: if (z_in) begin
          if (alu_op <= 4'd10) begin
            zlo <= alu_result;
            zhi <= '0;
          end else if (alu_op == 4'd11) begin
            is_div  <= 1'b0;
            cnt     <= '0;
            booth_p <= {{(WIDTH + 1){1'b0}}, bus, 1'b0};
            mcand   <= {y[WIDTH-1], y};
          end else if (alu_op == 4'd12) begin
            is_div <= 1'b1;
            cnt    <= '0;
            if (bus == '0) begin
              zlo <= '1;
              zhi <= y;
            end else begin
              div_rem <= '0;
              div_q   <= y_mag;
              div_d   <= bus_mag;
              neg_q   <= y[WIDTH-1] ^ bus[WIDTH-1];
              neg_r   <= y[WIDTH-1];
            end
          end else begin
            zlo <= '0;
            zhi <= '0;
          end
        end
        RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (is_div) begin
            div_q   <= div_q_next;
            div_rem <= div_rem_next;
          end else begin
            booth_p <= booth_next;
          end
          if (cnt == CNT_W'(WIDTH - 1)) begin
            if (is_div) begin
              zlo <= quot_final;
              zhi <= rem_final;
            end else begin
              {zhi, zlo} <= booth_next[2*WIDTH:1];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Bus-loaded registers; increment wins over a PC load
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      pc       <= '0;
      y        <= '0;
      hi       <= '0;
      lo       <= '0;
      c_reg    <= '0;
      mar_addr <= '0;
      mdr_out  <= '0;
      out_port <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) if (reg_in[i]) regs[i] <= bus;
      if (inc_pc)     pc <= pc + WIDTH'(1);
      else if (pc_in) pc <= bus;
      if (y_in)   y        <= bus;
      if (hi_in)  hi       <= bus;
      if (lo_in)  lo       <= bus;
      if (c_in)   c_reg    <= bus;
      if (mar_in) mar_addr <= bus[ADDR_W-1:0];
      if (out_in) out_port <= bus;
      if (mdr_in) mdr_out  <= mdr_read ? mem_data_in : bus;
    end
  end

endmodule

// File: tb/tb_datapath_mc.sv
// tb_datapath_mc: randomized self-checking bench for datapath_mc against a
// behavioural model built from plain arithmetic.
module tb_datapath_mc;

  localparam int W = 32;
  localparam logic [4:0] S_HI = 5'd16, S_LO = 5'd17, S_ZHI = 5'd18, S_ZLO = 5'd19;
  localparam logic [4:0] S_PC = 5'd20, S_MDR = 5'd21, S_C = 5'd22, S_IN = 5'd23;

  logic        clk, clr;
  logic [4:0]  src_sel;
  logic        src_en, ba_out;
  logic [15:0] reg_in;
  logic        pc_in, y_in, hi_in, lo_in, c_in, mar_in, out_in, inc_pc;
  logic        mdr_in, mdr_read, z_in;
  logic [31:0] mem_data_in, in_port;
  logic [3:0]  alu_op;
  logic [31:0] bus, mdr_out, out_port;
  logic [8:0]  mar_addr;
  logic        alu_busy, alu_done;

  int n_cmp = 0;
  int n_err = 0;

  datapath_mc dut (
    .clk(clk), .clr(clr), .src_sel(src_sel), .src_en(src_en), .ba_out(ba_out),
    .reg_in(reg_in), .pc_in(pc_in), .y_in(y_in), .hi_in(hi_in), .lo_in(lo_in),
    .c_in(c_in), .mar_in(mar_in), .out_in(out_in), .inc_pc(inc_pc),
    .mdr_in(mdr_in), .mdr_read(mdr_read), .mem_data_in(mem_data_in),
    .in_port(in_port), .alu_op(alu_op), .z_in(z_in), .bus(bus),
    .mdr_out(mdr_out), .mar_addr(mar_addr), .out_port(out_port),
    .alu_busy(alu_busy), .alu_done(alu_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of the single-cycle ops, shifts done one bit at a time
  function automatic logic [31:0] alu_model(input int op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    int s;
    s = int'(b[4:0]);
    r = a;
    case (op)
      0:  r = a + b;
      1:  r = a - b;
      2:  r = a & b;
      3:  r = a | b;
      4:  for (int i = 0; i < s; i++) r = {1'b0, r[31:1]};
      5:  for (int i = 0; i < s; i++) r = {r[31], r[31:1]};
      6:  for (int i = 0; i < s; i++) r = {r[30:0], 1'b0};
      7:  for (int i = 0; i < s; i++) r = {r[0], r[31:1]};
      8:  for (int i = 0; i < s; i++) r = {r[30:0], r[31]};
      9:  r = 32'd0 - b;
      10: r = ~b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Reference model of mul/div: returns {ZHI, ZLO}
  function automatic logic [63:0] muldiv_model(input int op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p, qv, rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 11) begin
      p = sa * sb;
      return p;
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    q = sa / sb;
    r = sa % sb;
    qv = q;
    rv = r;
    return {rv[31:0], qv[31:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    src_sel = S_IN; src_en = 1'b1; ba_out = 1'b0; reg_in = '0;
    pc_in = 0; y_in = 0; hi_in = 0; lo_in = 0; c_in = 0; mar_in = 0; out_in = 0;
    inc_pc = 0; mdr_in = 0; mdr_read = 0; z_in = 0; alu_op = 4'd0;
    mem_data_in = '0; in_port = '0;
  endtask

  task automatic drive_in(input logic [31:0] v);
    in_port = v; src_sel = S_IN; src_en = 1'b1; ba_out = 1'b0;
  endtask

  task automatic read_src(input logic [4:0] sel, output logic [31:0] v);
    src_sel = sel; src_en = 1'b1; ba_out = 1'b0;
    #1;
    v = bus;
  endtask

  task automatic set_y(input logic [31:0] v);
    drive_in(v); y_in = 1'b1; tick(); y_in = 1'b0;
  endtask

  task automatic do_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    set_y(a); drive_in(b); alu_op = 4'(op); z_in = 1'b1; tick(); z_in = 1'b0;
  endtask

  // Starts a mul/div, waits (bounded) for alu_done and reads Z while in DONE
  task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b,
                        output int cycles, output logic busy0,
                        output logic [31:0] zl, output logic [31:0] zh);
    set_y(a); drive_in(b); alu_op = 4'(op); z_in = 1'b1; tick(); z_in = 1'b0;
    busy0 = alu_busy;
    cycles = 0;
    for (int c = 1; c <= 100; c++) begin
      if (alu_done) begin cycles = c; break; end
      tick();
    end
    read_src(S_ZLO, zl);
    read_src(S_ZHI, zh);
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] v;
    drive_in(32'h1234); reg_in = 16'h0008; pc_in = 1; out_in = 1; tick();
    reg_in = '0; pc_in = 0; out_in = 0;
    do_alu(0, 32'd1, 32'd2);
    read_src(5'd3, v);
    n_cmp++; if (v !== 32'h1234) begin n_err++; $display("[TB] FAIL r3_loaded: got %h expected %h", v, 32'h1234); end
    #1 clr = 1'b1;
    read_src(5'd3, v);
    n_cmp++; if (v !== 32'd0) begin n_err++; $display("[TB] FAIL reset_r3: got %h expected 0", v); end
    read_src(S_PC, v);
    n_cmp++; if (v !== 32'd0) begin n_err++; $display("[TB] FAIL reset_pc: got %h expected 0", v); end
    read_src(S_ZLO, v);
    n_cmp++; if (v !== 32'd0) begin n_err++; $display("[TB] FAIL reset_zlo: got %h expected 0", v); end
    n_cmp++; if (out_port !== 32'd0) begin n_err++; $display("[TB] FAIL reset_out: got %h expected 0", out_port); end
    n_cmp++; if (alu_busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %b expected 0", alu_busy); end
    clr = 1'b0;
    tick();
  endtask

  task automatic test_transfer();
    logic [31:0] v, val;
    int r;
    drive_in(32'hDEAD_BEEF); reg_in = 16'h0020; out_in = 1; mar_in = 1; hi_in = 1; tick();
    reg_in = '0; out_in = 0; mar_in = 0; hi_in = 0;
    n_cmp++; if (out_port !== 32'hDEAD_BEEF) begin n_err++; $display("[TB] FAIL out_port: got %h expected deadbeef", out_port); end
    n_cmp++; if (mar_addr !== 9'h0EF) begin n_err++; $display("[TB] FAIL mar_addr: got %h expected 0ef", mar_addr); end
    read_src(5'd5, v);
    n_cmp++; if (v !== 32'hDEAD_BEEF) begin n_err++; $display("[TB] FAIL r5: got %h expected deadbeef", v); end
    read_src(S_HI, v);
    n_cmp++; if (v !== 32'hDEAD_BEEF) begin n_err++; $display("[TB] FAIL hi: got %h expected deadbeef", v); end
    mem_data_in = 32'h1357_2468; mdr_read = 1; mdr_in = 1; tick(); mdr_in = 0; mdr_read = 0;
    read_src(S_MDR, v);
    n_cmp++; if (v !== 32'h1357_2468) begin n_err++; $display("[TB] FAIL mdr_mem: got %h expected 13572468", v); end
    drive_in(32'h0000_CAFE); mdr_in = 1; tick(); mdr_in = 0;
    n_cmp++; if (mdr_out !== 32'h0000_CAFE) begin n_err++; $display("[TB] FAIL mdr_bus: got %h expected 0000cafe", mdr_out); end
    drive_in(32'd7); reg_in = 16'h0001; tick(); reg_in = '0;
    src_sel = 5'd0; ba_out = 1; #1;
    n_cmp++; if (bus !== 32'd0) begin n_err++; $display("[TB] FAIL ba_out: got %h expected 0", bus); end
    ba_out = 0; #1;
    n_cmp++; if (bus !== 32'd7) begin n_err++; $display("[TB] FAIL r0_read: got %h expected 7", bus); end
    src_en = 0; #1;
    n_cmp++; if (bus !== 32'd0) begin n_err++; $display("[TB] FAIL src_en_off: got %h expected 0", bus); end
    src_en = 1; src_sel = 5'd27; #1;
    n_cmp++; if (bus !== 32'd0) begin n_err++; $display("[TB] FAIL sel_oob: got %h expected 0", bus); end
    for (int i = 0; i < 8; i++) begin
      r = $urandom_range(1, 15);
      val = $urandom;
      drive_in(val); reg_in = 16'(1 << r); lo_in = 1; c_in = 1; tick();
      reg_in = '0; lo_in = 0; c_in = 0;
      read_src(5'(r), v);
      n_cmp++; if (v !== val) begin n_err++; $display("[TB] FAIL rand_reg%0d: got %h expected %h", r, v, val); end
      read_src(S_LO, v);
      n_cmp++; if (v !== val) begin n_err++; $display("[TB] FAIL rand_lo: got %h expected %h", v, val); end
      read_src(S_C, v);
      n_cmp++; if (v !== val) begin n_err++; $display("[TB] FAIL rand_c: got %h expected %h", v, val); end
    end
  endtask

  task automatic test_alu();
    int          ops [3] = '{5, 7, 0};
    logic [31:0] as  [3] = '{32'h8000_0000, 32'h1, 32'hFFFF_FFFF};
    logic [31:0] bs  [3] = '{32'd4, 32'd1, 32'd1};
    logic [31:0] exs [3] = '{32'hF800_0000, 32'h8000_0000, 32'h0};
    logic [31:0] zl, zh, exp_v, a, b;
    int op;
    for (int i = 0; i < 3; i++) begin
      do_alu(ops[i], as[i], bs[i]);
      read_src(S_ZLO, zl);
      read_src(S_ZHI, zh);
      n_cmp++; if (zl !== exs[i]) begin n_err++; $display("[TB] FAIL alu_dir%0d_zlo: got %h expected %h", i, zl, exs[i]); end
      n_cmp++; if (zh !== 32'd0) begin n_err++; $display("[TB] FAIL alu_dir%0d_zhi: got %h expected 0", i, zh); end
    end
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 13);
      if (op >= 11) op += 2;
      a = $urandom;
      b = $urandom;
      do_alu(op, a, b);
      exp_v = alu_model(op, a, b);
      read_src(S_ZLO, zl);
      read_src(S_ZHI, zh);
      n_cmp++; if (zl !== exp_v) begin n_err++; $display("[TB] FAIL alu_op%0d_zlo a=%h b=%h: got %h expected %h", op, a, b, zl, exp_v); end
      n_cmp++; if (zh !== 32'd0) begin n_err++; $display("[TB] FAIL alu_op%0d_zhi: got %h expected 0", op, zh); end
    end
  endtask

  task automatic test_muldiv();
    int          ops [7] = '{11, 12, 12, 12, 11, 12, 11};
    logic [31:0] as  [7] = '{32'hFFFF_FFFD, 32'hFFFF_FFEF, 32'd9, 32'h8000_0000, 32'h8000_0000, 32'd7, 32'h7FFF_FFFF};
    logic [31:0] bs  [7] = '{32'd7, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    logic [31:0] zl, zh, a, b;
    logic [63:0] exp_z;
    logic        busy0;
    int          cycles, exp_c, op;
    run_op(12, 32'hFFFF_FFEF, 32'd5, cycles, busy0, zl, zh);
    n_cmp++; if (zl !== 32'hFFFF_FFFD) begin n_err++; $display("[TB] FAIL div_m17_5_q: got %h expected fffffffd", zl); end
    n_cmp++; if (zh !== 32'hFFFF_FFFE) begin n_err++; $display("[TB] FAIL div_m17_5_r: got %h expected fffffffe", zh); end
    run_op(12, 32'd9, 32'd0, cycles, busy0, zl, zh);
    n_cmp++; if (cycles !== 1) begin n_err++; $display("[TB] FAIL div0_latency: got %0d expected 1", cycles); end
    n_cmp++; if ({zh, zl} !== {32'd9, 32'hFFFF_FFFF}) begin n_err++; $display("[TB] FAIL div0_z: got %h_%h expected 00000009_ffffffff", zh, zl); end
    for (int i = 0; i < 19; i++) begin
      if (i < 7) begin
        op = ops[i]; a = as[i]; b = bs[i];
      end else begin
        op = (i % 2 == 0) ? 11 : 12;
        a = $urandom;
        b = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
        if (i % 4 == 0) b = -b;
      end
      run_op(op, a, b, cycles, busy0, zl, zh);
      exp_z = muldiv_model(op, a, b);
      exp_c = (op == 12 && b == 32'd0) ? 1 : W + 1;
      n_cmp++; if (busy0 !== 1'b1) begin n_err++; $display("[TB] FAIL md%0d_busy: got %b expected 1", i, busy0); end
      n_cmp++; if (cycles !== exp_c) begin n_err++; $display("[TB] FAIL md%0d_latency: got %0d expected %0d", i, cycles, exp_c); end
      n_cmp++; if ({zh, zl} !== exp_z) begin n_err++; $display("[TB] FAIL md%0d_op%0d a=%h b=%h: got %h_%h expected %h", i, op, a, b, zh, zl, exp_z); end
      n_cmp++; if (alu_busy !== 1'b0 || alu_done !== 1'b0) begin n_err++; $display("[TB] FAIL md%0d_idle: got busy=%b done=%b expected 0 0", i, alu_busy, alu_done); end
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] zl, zh, v;
    int cycles;
    do_alu(0, 32'd5, 32'd6);
    set_y(32'hFFFF_FFFD);
    drive_in(32'd7); alu_op = 4'd11; z_in = 1; tick(); z_in = 0;
    cycles = 0;
    for (int c = 1; c <= 100; c++) begin
      if (alu_done) begin cycles = c; break; end
      if (c == 5) begin
        read_src(S_ZLO, v);
        n_cmp++; if (v !== 32'd11) begin n_err++; $display("[TB] FAIL zlo_during_run: got %h expected 0000000b", v); end
      end
      if (c == 10) begin drive_in(32'h77); alu_op = 4'd0; z_in = 1; y_in = 1; end
      tick();
      if (c == 10) begin z_in = 0; y_in = 0; end
    end
    read_src(S_ZLO, zl);
    read_src(S_ZHI, zh);
    tick();
    n_cmp++; if (cycles !== 33) begin n_err++; $display("[TB] FAIL mul_latency: got %0d expected 33", cycles); end
    n_cmp++; if (zh !== 32'hFFFF_FFFF) begin n_err++; $display("[TB] FAIL mul_zhi: got %h expected ffffffff", zh); end
    n_cmp++; if (zl !== 32'hFFFF_FFEB) begin n_err++; $display("[TB] FAIL mul_zlo: got %h expected ffffffeb", zl); end
    drive_in(32'd1); alu_op = 4'd0; z_in = 1; tick(); z_in = 0;
    read_src(S_ZLO, v);
    n_cmp++; if (v !== 32'h78) begin n_err++; $display("[TB] FAIL y_loaded_while_busy: got %h expected 00000078", v); end
  endtask

  task automatic test_abort_pc();
    logic [31:0] v;
    int dones;
    set_y(32'hFFFF_FFFD);
    drive_in(32'd7); alu_op = 4'd11; z_in = 1; tick(); z_in = 0;
    repeat (14) tick();
    #1 clr = 1'b1; #1;
    n_cmp++; if (alu_busy !== 1'b0) begin n_err++; $display("[TB] FAIL abort_busy: got %b expected 0", alu_busy); end
    clr = 1'b0;
    dones = 0;
    for (int c = 0; c < 40; c++) begin tick(); if (alu_done) dones++; end
    n_cmp++; if (dones !== 0) begin n_err++; $display("[TB] FAIL abort_done: got %0d pulses expected 0", dones); end
    read_src(S_ZLO, v);
    n_cmp++; if (v !== 32'd0) begin n_err++; $display("[TB] FAIL abort_zlo: got %h expected 0", v); end
    drive_in(32'd5); pc_in = 1; tick(); pc_in = 0;
    inc_pc = 1; tick(); inc_pc = 0;
    read_src(S_PC, v);
    n_cmp++; if (v !== 32'd6) begin n_err++; $display("[TB] FAIL pc_inc: got %h expected 6", v); end
    drive_in(32'hFFFF_FFFF); pc_in = 1; tick();
    drive_in(32'h55); inc_pc = 1; tick(); inc_pc = 0; pc_in = 0;
    read_src(S_PC, v);
    n_cmp++; if (v !== 32'd0) begin n_err++; $display("[TB] FAIL pc_wrap: got %h expected 0", v); end
  endtask

  initial begin
    drive_idle();
    clr = 1'b1;
    repeat (2) tick();
    clr = 1'b0;
    tick();
    test_reset();
    test_transfer();
    test_alu();
    test_muldiv();
    test_busy_ignore();
    test_abort_pc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
